// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract with carry, signed-overflow and optional saturation.
// Skid-free valid/ready pipeline of STAGES slices; bubbles collapse via the ready chain.
module addsub_pipe #(
  parameter int WIDTH  = 36,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf
);

  logic [WIDTH-1:0]  w_bx;
  logic [WIDTH:0]    w_sum;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_res;
  logic [STAGES-1:0] w_rdy;
  logic              w_full_tail;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_carry;
  logic [STAGES-1:0] r_ovf;
  logic [WIDTH-1:0]  r_res [STAGES];

  assign w_bx  = in_sub ? ~in_b : in_b;
  assign w_sum = {1'b0, in_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, in_sub};
  assign w_ovf = (in_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    if (in_sat && w_ovf) begin
      w_res = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // rdy[k] = out_ready OR any empty slice at or after k; flattened to avoid a bit-to-bit loop
  always_comb begin
    w_full_tail = 1'b1;
    w_rdy       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_full_tail = w_full_tail & r_v[k];
      w_rdy[k]    = out_ready | ~w_full_tail;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v     <= '0;
      r_carry <= '0;
      r_ovf   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
      end
    end else begin
      if (w_rdy[0]) begin
        r_v[0]     <= in_valid;
        r_res[0]   <= w_res;
        r_carry[0] <= w_sum[WIDTH];
        r_ovf[0]   <= w_ovf;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k]     <= r_v[k-1];
          r_res[k]   <= r_res[k-1];
          r_carry[k] <= r_carry[k-1];
          r_ovf[k]   <= r_ovf[k-1];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[STAGES-1];
  assign out_res   = r_res[STAGES-1];
  assign out_carry = r_carry[STAGES-1];
  assign out_ovf   = r_ovf[STAGES-1];

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two-operand add/subtract unit with valid/ready handshakes on both sides.
- Generalises the fixed 36-bit combinational add/sub datapath:
  - configurable width and pipeline depth;
  - per-transaction add/sub select, carry and signed-overflow flags, optional signed saturation;
  - full backpressure.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 36, operand/result width in bits; legal range >= 2.
- STAGES, 2, pipeline register slices from input accept to output; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  unit can accept operands this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- in_sat  input  1  1 = saturate result on signed overflow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result this cycle.
- out_res  output  WIDTH  result.
- out_carry  output  1  carry out of MSB. For sub this is NOT-borrow.
- out_ovf  output  1  signed overflow of the unsaturated result.

Behaviour:
- Arithmetic is computed combinationally on accept and captured into stage 0:
  - bx = in_sub ? ~in_b : in_b.
  - {carry, sum} = in_a + bx + in_sub, computed (WIDTH+1) bits wide.
  - ovf = (in_a[MSB] == bx[MSB]) && (sum[MSB] != in_a[MSB]).
  - If in_sat && ovf: res = in_a[MSB] ? {1, 0...0} : {0, 1...1}. Otherwise res = sum.
  - carry and ovf always reflect the unsaturated sum.
- Pipeline: STAGES slices, each holding a valid bit plus {res, carry, ovf}. Stage STAGES-1 drives the out_* ports.
- Ready chain, combinational:
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0].
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Slice update each cycle:
  - If rdy[k] is set, slice k loads from its upstream: the input for k=0, slice k-1 otherwise.
  - The loaded valid bit is the upstream valid (in_valid for k=0).
  - If rdy[k] is clear, slice k holds its contents.
- Consequences:
  - Bubbles collapse.
  - Full throughput of 1 result/cycle when out_ready is held high.
  - Latency = STAGES cycles from input transfer to out_valid when unstalled.
- Ordering: strict FIFO order; no reordering or dropping.
- While out_valid && !out_ready, out_res, out_carry and out_ovf are stable.
- When full (all v set) and out_ready low: in_ready = 0 in the same cycle.
- Simultaneous full and out_ready high: in_ready = 1, and input and output both transfer in that cycle.
- in_a, in_b, in_sub and in_sat are don't-care when in_valid is low. A slice loaded with valid 0 may take any data.
- Reset (asynchronous, any time, including mid-stream):
  - All valid bits and all data registers are cleared immediately.
  - Outputs: out_valid = 0, out_res = 0, out_carry = 0, out_ovf = 0.
  - in_ready = 1 while reset is asserted and after it is released.
  - In-flight transactions are discarded; the first input after release behaves as in an empty pipe.
- No combinational path from in_* to out_*. Only out_ready reaches in_ready combinationally.

Test Plan (WIDTH=36, STAGES=2 unless stated):
- Add wrap: A=0xFFFFFFFFF, B=0x1, sub=0, sat=0, out_ready=1
  -> two cycles later: res=0x000000000, carry=1, ovf=0.
- Subtract borrow: A=5, B=7, sub=1
  -> res=0xFFFFFFFFE, carry=0, ovf=0.
  - Also: A=7, B=5 -> res=2, carry=1.
- Signed overflow/saturation, each case run with sat=0 and sat=1:
  - A=0x7FFFFFFFF + B=1 -> ovf=1; sat=0 gives res=0x800000000, sat=1 gives res=0x7FFFFFFFF.
  - A=0x800000000 - B=1 -> ovf=1; sat=1 gives res=0x800000000, sat=0 gives res=0x7FFFFFFFF.
- Backpressure: offer 4 consecutive adds (i+i for i=1..4) with out_ready=0
  -> in_ready falls after 2 accepts; out_res holds 2 stable.
  - Then raise out_ready -> results 2, 4, 6, 8 in order.
  - 1 result per cycle, with in_ready re-asserting the same cycle.
- Throughput, with STAGES=1 and STAGES=8: 100-item random stream with out_ready=1
  -> exactly STAGES cycles of latency; zero in_ready drops.
  - Also: random out_ready toggling -> results match the golden model and preserve order.
- Reset mid-stream: assert reset with 2 valid in flight
  -> out_valid=0 and all outputs 0 immediately (before the next edge).
  - After release, one add of 3+4 -> res=7 after STAGES cycles; no stale result ever emitted.
